link_frame_tx: RTL and testbench
================================

# link_frame_tx

Serial frame transmitter carrying the local player's game state to the opponent board. Sits downstream of the action state machine: each `data_out_valid` pulse offers one `data_t` snapshot plus the scored flag. The block buffers the snapshot and serialises it LSB-first onto a single idle-high wire, one frame per snapshot. It is the sending end of the inter-board link whose receiving end produces `syncer_in_valid`, `opponent_data_in` and `opponent_scored_in`.

## Interface
- `DATA_WIDTH`, 89, width of `data_t` payload.
- `CLKS_PER_BIT`, 64, clock cycles per serial bit; must be ≥ 2.
- `clk_pixel_in`  input  1  pixel clock; all logic on its rising edge.
- `rst_n_in`  input  1  reset; one clock; reset is asynchronous and active-low.
- `data_in`  input  DATA_WIDTH  player snapshot, `data_t` packing.
- `scored_in`  input  1  player-scored flag for this snapshot.
- `data_in_valid`  input  1  single-cycle strobe; `data_in`/`scored_in` valid this cycle.
- `tx_out`  output  1  serial line, idle high.
- `busy_out`  output  1  high from frame load through last stop-bit cycle.
- `frame_sent_out`  output  1  one-cycle pulse when a frame's stop bit completes.
- `dropped_out`  output  1  one-cycle pulse when an unsent pending snapshot is overwritten.

## Operation
- Payload P = {`scored_in`, `data_in`} (DATA_WIDTH+1 = 90 bits); bit 0 of `data_in` sent first, `scored_in` last.
- Frame: start (0), 90 payload bits, parity (optional, see Configuration), stop (1). Each bit held exactly CLKS_PER_BIT cycles.
- One-entry pending buffer: every `data_in_valid` writes P into pending and sets pending_full. Latest snapshot wins.
- If pending_full already set and not consumed in the same cycle, the old entry is overwritten and `dropped_out` pulses the next cycle.
- If pending is consumed and written in the same cycle, the new value lands in pending, no drop.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx_out`=1; if pending_full, load shift register from pending, clear pending_full, go START.
  - START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out 90 bits; bit counter 0..89, then PARITY (or STOP if parity compiled out).
  - PARITY: `tx_out` = XOR of all 90 payload bits (even parity).
  - STOP: `tx_out`=1 for CLKS_PER_BIT cycles. On the final cycle, pulse `frame_sent_out`. If pending_full, load and go straight to START; otherwise go IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Bit counter width $clog2(DATA_WIDTH+1).
- `tx_out`, `busy_out`, `frame_sent_out` and `dropped_out` are all registered.

## Timing
- Reset values, applied asynchronously on `rst_n_in`=0: `tx_out`=1, `busy_out`=0, `frame_sent_out`=0, `dropped_out`=0, FSM=IDLE, pending_full=0, counters 0.
- Reset mid-frame aborts the frame and drives the line high immediately. Nothing resumes after reset deasserts.
- Latency, IDLE with pending empty: strobe sampled at edge N → pending at N+1 → `tx_out`=0 and `busy_out`=1 after edge N+2.
- Frame length: 93 bits with parity, 92 without. Stop-to-start turnaround when pending is full: zero extra cycles beyond the stop bit.
- `frame_sent_out` is asserted after the edge ending the final stop cycle and lasts one cycle. `busy_out` falls on the same edge unless the next frame is chained.
- A strobe arriving during an active frame is never lost unless overwritten by a later strobe before that frame ends.

## Configuration
- `LINK_TX_PARITY_EN` defined: PARITY state present, 93-bit frame, even parity bit after the payload.
- Not defined: PARITY state removed, DATA goes directly to STOP, 92-bit frame. The receiver must be built with the same setting.

## Test plan
- Reset and idle, CLKS_PER_BIT=4: hold `rst_n_in`=0 → `tx_out`=1 and all pulses 0. Release with no strobe → line stays 1 for 1000 cycles.
- Single frame: `data_in`=89'h1, `scored_in`=1, strobe at edge 10 → start bit low over cycles 12-15, bit 0 = 1, bits 1-88 = 0, bit 89 = 1. With parity the parity bit = 0, then stop bit; `frame_sent_out` pulses once after 93×4 cycles.
- Back-to-back: strobe A, then strobe B during A's DATA state → B's start bit begins the cycle after A's stop bit ends; one `frame_sent_out` per frame; `dropped_out` stays 0.
- Overwrite: strobes A, B, C during one active frame → C transmitted next; `dropped_out` pulses exactly once (B overwritten by C).
- Async reset mid-DATA: drop `rst_n_in` at bit 40 → `tx_out`=1 with no clock edge; no `frame_sent_out`; pending cleared.
- Parity compiled out: same stimulus as the single-frame scenario → 92-bit frame with the stop bit directly after payload bit 89.

Source files
------------

// File: rtl/link_frame_tx_if.sv
// Snapshot handshake and serial-line status bundle for link_frame_tx.
// The master drives snapshots in and observes the line; the slave is the transmitter.
interface link_frame_tx_if #(
  parameter int DATA_WIDTH = 89
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  scored_in;
  logic                  data_in_valid;
  logic                  tx_out;
  logic                  busy_out;
  logic                  frame_sent_out;
  logic                  dropped_out;

  modport master (
    output data_in,
    output scored_in,
    output data_in_valid,
    input  tx_out,
    input  busy_out,
    input  frame_sent_out,
    input  dropped_out
  );

  modport slave (
    input  data_in,
    input  scored_in,
    input  data_in_valid,
    output tx_out,
    output busy_out,
    output frame_sent_out,
    output dropped_out
  );
endinterface

// File: rtl/link_frame_tx.sv
// Buffers one game-state snapshot and serialises it LSB-first on an idle-high line.
// Define LINK_TX_PARITY_EN to append an even-parity bit after the payload.
module link_frame_tx #(
  parameter int DATA_WIDTH   = 89,
  parameter int CLKS_PER_BIT = 64
) (
  input  logic           clk_pixel_in,
  input  logic           rst_n_in,
  link_frame_tx_if.slave link
);

  localparam int PAYLOAD_W = DATA_WIDTH + 1;
  localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = $clog2(PAYLOAD_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_W - 1);

`ifdef LINK_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baudCnt_q, baudCnt_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [PAYLOAD_W-1:0] shiftReg_q, shiftReg_d;
  logic [PAYLOAD_W-1:0] pending_q, pending_d;
  logic                 pendingFull_q, pendingFull_d;
`ifdef LINK_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 tx_q, txNext;
  logic                 busy_q;
  logic                 stopLast_q, stopLast_d;
  logic                 frameSent_q;
  logic                 dropped_q, dropped_d;
  logic                 baudLast;
  logic                 consume;

  // Line value, busy and frame-done are decoded from the current state and
  // registered, so the wire trails the state machine by exactly one cycle.
  always_comb begin
    state_d       = state_q;
    baudCnt_d     = baudCnt_q;
    bitCnt_d      = bitCnt_q;
    shiftReg_d    = shiftReg_q;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
`ifdef LINK_TX_PARITY_EN
    parity_d      = parity_q;
`endif
    stopLast_d    = 1'b0;
    dropped_d     = 1'b0;
    txNext        = 1'b1;
    consume       = 1'b0;
    baudLast      = (baudCnt_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (pendingFull_q) begin
          consume   = 1'b1;
          state_d   = ST_START;
          baudCnt_d = '0;
          bitCnt_d  = '0;
        end
      end

      ST_START: begin
        txNext = 1'b0;
        if (baudLast) begin
          baudCnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        txNext = shiftReg_q[0];
        if (baudLast) begin
          baudCnt_d  = '0;
          shiftReg_d = shiftReg_q >> 1;
          if (bitCnt_q == BIT_LAST) begin
            bitCnt_d = '0;
`ifdef LINK_TX_PARITY_EN
            state_d  = ST_PARITY;
`else
            state_d  = ST_STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

`ifdef LINK_TX_PARITY_EN
      ST_PARITY: begin
        txNext = parity_q;
        if (baudLast) begin
          baudCnt_d = '0;
          state_d   = ST_STOP;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        txNext = 1'b1;
        if (baudLast) begin
          stopLast_d = 1'b1;
          baudCnt_d  = '0;
          bitCnt_d   = '0;
          if (pendingFull_q) begin
            consume = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        baudCnt_d = '0;
        bitCnt_d  = '0;
      end
    endcase

    if (consume) begin
      shiftReg_d    = pending_q;
      pendingFull_d = 1'b0;
`ifdef LINK_TX_PARITY_EN
      parity_d      = ^pending_q;
`endif
    end

    // A strobe always lands in pending; it only counts as a drop when the
    // previous snapshot is still waiting and is not being loaded this cycle.
    if (link.data_in_valid) begin
      pending_d     = {link.scored_in, link.data_in};
      pendingFull_d = 1'b1;
      dropped_d     = pendingFull_q & ~consume;
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      baudCnt_q     <= '0;
      bitCnt_q      <= '0;
      shiftReg_q    <= '0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
`ifdef LINK_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      stopLast_q    <= 1'b0;
      frameSent_q   <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      baudCnt_q     <= baudCnt_d;
      bitCnt_q      <= bitCnt_d;
      shiftReg_q    <= shiftReg_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
`ifdef LINK_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
      tx_q          <= txNext;
      busy_q        <= (state_q != ST_IDLE);
      stopLast_q    <= stopLast_d;
      frameSent_q   <= stopLast_q;
      dropped_q     <= dropped_d;
    end
  end

  assign link.tx_out         = tx_q;
  assign link.busy_out       = busy_q;
  assign link.frame_sent_out = frameSent_q;
  assign link.dropped_out    = dropped_q;

endmodule

// File: tb/tb_link_frame_tx.sv
// Self-checking bench for link_frame_tx: table-driven single frames, directed
// chaining/overwrite/reset sequences and random strobes against a line-level model.
module tb_link_frame_tx;

  localparam int DW  = 89;
  localparam int CPB = 4;
  localparam int PW  = DW + 1;
`ifdef LINK_TX_PARITY_EN
  localparam int FRAME_BITS = PW + 3;
`else
  localparam int FRAME_BITS = PW + 2;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  link_frame_tx_if #(.DATA_WIDTH(DW)) linkIf ();

  link_frame_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_pixel_in(clk),
    .rst_n_in    (rstN),
    .link        (linkIf)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input logic scored);
    @(negedge clk);
    linkIf.data_in       = data;
    linkIf.scored_in     = scored;
    linkIf.data_in_valid = 1'b1;
    @(negedge clk);
    linkIf.data_in_valid = 1'b0;
  endtask

  // Line model: every frame is expanded into one expected wire value per cycle.
  // The line is free when no expected values remain after the current cycle.
  typedef struct packed {
    logic value;
    logic last;
  } wireSlot_t;

  wireSlot_t     lineQ[$];
  logic [PW-1:0] mPending = '0;
  bit            mFull    = 0;
  bit            expTx    = 1;
  bit            expBusy  = 0;
  bit            expSent  = 0;
  bit            expDrop  = 0;
  bit            sentNext = 0;

  function automatic void pushFrame(input logic [PW-1:0] payload);
    logic [FRAME_BITS-1:0] bits;
    bits          = '0;
    bits[PW:1]    = payload;
`ifdef LINK_TX_PARITY_EN
    bits[PW+1]    = ^payload;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++)
      for (int c = 0; c < CPB; c++)
        lineQ.push_back('{value: bits[b], last: (b == FRAME_BITS - 1 && c == CPB - 1)});
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lineQ.delete();
      mFull    = 0;
      expTx    = 1;
      expBusy  = 0;
      expSent  = 0;
      expDrop  = 0;
      sentNext = 0;
    end else begin
      wireSlot_t slot;
      expSent  = sentNext;
      sentNext = 0;
      if (lineQ.size() > 0) begin
        slot     = lineQ.pop_front();
        expTx    = slot.value;
        expBusy  = 1;
        sentNext = slot.last;
      end else begin
        expTx   = 1;
        expBusy = 0;
      end
      if (lineQ.size() == 0 && mFull) begin
        pushFrame(mPending);
        mFull = 0;
      end
      expDrop = 0;
      if (linkIf.data_in_valid === 1'b1) begin
        expDrop  = mFull;
        mPending = {linkIf.scored_in, linkIf.data_in};
        mFull    = 1;
      end
    end
  end

  bit sbEnable = 0;
  always @(negedge clk) begin
    if (sbEnable)
      checkOutput("lineState",
                  {linkIf.tx_out, linkIf.busy_out, linkIf.frame_sent_out, linkIf.dropped_out},
                  {expTx, expBusy, expSent, expDrop});
  end

  int sentPulses  = 0;
  int dropPulses  = 0;
  int txLowCycles = 0;
  always @(negedge clk) begin
    if (linkIf.frame_sent_out === 1'b1) sentPulses++;
    if (linkIf.dropped_out === 1'b1)    dropPulses++;
    if (linkIf.tx_out === 1'b0)         txLowCycles++;
  end

  task automatic waitForSent(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (linkIf.frame_sent_out === 1'b1) seen = 1;
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          scored;
    logic          expParity;
  } vector_t;

  vector_t               vectors[5];
  logic [FRAME_BITS-1:0] cap;
  logic [PW-1:0]         got;
  logic [PW-1:0]         expPayload;
  logic [95:0]           rnd;
  logic [DW-1:0]         dataA, dataB, dataC;
  bit                    seen;
  int                    sentBase, dropBase, lowBase;

  initial begin
    vectors[0] = '{data: 89'h1,           scored: 1'b1, expParity: 1'b0};
    vectors[1] = '{data: 89'h0,           scored: 1'b0, expParity: 1'b0};
    vectors[2] = '{data: '1,              scored: 1'b0, expParity: 1'b1};
    vectors[3] = '{data: 89'h7,           scored: 1'b0, expParity: 1'b1};
    vectors[4] = '{data: {1'b1, 88'h0},   scored: 1'b1, expParity: 1'b0};

    linkIf.data_in       = '0;
    linkIf.scored_in     = 1'b0;
    linkIf.data_in_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("resetTx",    linkIf.tx_out, 1'b1);
    checkOutput("resetBusy",  linkIf.busy_out, 1'b0);
    checkOutput("resetSent",  linkIf.frame_sent_out, 1'b0);
    checkOutput("resetDrop",  linkIf.dropped_out, 1'b0);
    rstN     = 1'b1;
    sbEnable = 1;

    lowBase = txLowCycles;
    repeat (1000) @(negedge clk);
    checkOutput("idleLineLow", txLowCycles - lowBase, 0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vectors[v].data, vectors[v].scored);
      @(posedge clk); #1;
      checkOutput("loadCycleTx",   linkIf.tx_out, 1'b1);
      checkOutput("loadCycleBusy", linkIf.busy_out, 1'b0);
      @(posedge clk); #1;
      checkOutput("startLatencyTx",   linkIf.tx_out, 1'b0);
      checkOutput("startLatencyBusy", linkIf.busy_out, 1'b1);
      for (int k = 0; k < FRAME_BITS; k++) begin
        @(posedge clk); #1;
        cap[k] = linkIf.tx_out;
        repeat (CPB - 1) @(posedge clk);
      end
      #1;
      checkOutput("frameSentTiming", linkIf.frame_sent_out, 1'b1);
      checkOutput("busyFallTiming",  linkIf.busy_out, 1'b0);
      expPayload = {vectors[v].scored, vectors[v].data};
      checkOutput("startBit", cap[0], 1'b0);
      checkOutput("payload",  cap[PW:1], expPayload);
`ifdef LINK_TX_PARITY_EN
      checkOutput("parityBit", cap[PW+1], vectors[v].expParity);
`endif
      checkOutput("stopBit", cap[FRAME_BITS-1], 1'b1);
      repeat (5) @(negedge clk);
    end

    // Back-to-back: second snapshot arrives mid-frame and must chain with no gap.
    sentBase = sentPulses;
    dropBase = dropPulses;
    dataA = 89'h1_2345_6789_ABCD_EF01_2345;
    dataB = 89'h0_FEDC_BA98_7654_3210_FEDC;
    applyStimulus(dataA, 1'b0);
    repeat (30) @(negedge clk);
    applyStimulus(dataB, 1'b1);
    waitForSent(FRAME_CYCLES + 20, seen);
    checkOutput("chainFirstSent", seen, 1'b1);
    checkOutput("chainStartTx",   linkIf.tx_out, 1'b0);
    checkOutput("chainBusy",      linkIf.busy_out, 1'b1);
    waitForSent(FRAME_CYCLES + 20, seen);
    checkOutput("chainSecondSent", seen, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("chainSentCount", sentPulses - sentBase, 2);
    checkOutput("chainDropCount", dropPulses - dropBase, 0);

    // Overwrite: B is replaced by C before A finishes; C must be the next frame.
    sentBase = sentPulses;
    dropBase = dropPulses;
    dataC = 89'h0_0F0F_0F0F_0F0F_0F0F_0F0F;
    applyStimulus(dataA, 1'b1);
    repeat (30) @(negedge clk);
    applyStimulus(dataB, 1'b0);
    repeat (30) @(negedge clk);
    applyStimulus(dataC, 1'b1);
    waitForSent(FRAME_CYCLES + 20, seen);
    checkOutput("overwriteFirstSent", seen, 1'b1);
    repeat (CPB + 1) @(negedge clk);
    for (int k = 0; k < PW; k++) begin
      got[k] = linkIf.tx_out;
      repeat (CPB) @(negedge clk);
    end
    checkOutput("overwriteWinner", got, {1'b1, dataC});
    waitForSent(FRAME_CYCLES + 20, seen);
    checkOutput("overwriteSecondSent", seen, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("overwriteSentCount", sentPulses - sentBase, 2);
    checkOutput("overwriteDropCount", dropPulses - dropBase, 1);

    // Asynchronous reset in the middle of the payload, with a snapshot pending.
    applyStimulus(dataA, 1'b1);
    repeat (100) @(negedge clk);
    applyStimulus(dataB, 1'b0);
    repeat (66) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncResetTx",   linkIf.tx_out, 1'b1);
    checkOutput("asyncResetBusy", linkIf.busy_out, 1'b0);
    checkOutput("asyncResetSent", linkIf.frame_sent_out, 1'b0);
    repeat (3) @(negedge clk);
    rstN     = 1'b1;
    sentBase = sentPulses;
    lowBase  = txLowCycles;
    repeat (2 * FRAME_CYCLES) @(negedge clk);
    checkOutput("postResetSent",  sentPulses - sentBase, 0);
    checkOutput("postResetLineLow", txLowCycles - lowBase, 0);

    // Random strobes, including consecutive-cycle strobes and mid-frame arrivals.
    for (int i = 0; i < 30; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      applyStimulus(rnd[DW-1:0], rnd[95]);
      if ($urandom_range(0, 3) == 0)
        continue;
      repeat ($urandom_range(1, 450)) @(negedge clk);
    end
    repeat (3 * FRAME_CYCLES) @(negedge clk);
    checkOutput("drainIdle", linkIf.busy_out, 1'b0);

    sbEnable = 0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
